// File: rtl/seq_detector_prog.sv
// Run-time programmable serial bit-pattern detector with overlap control,
// input qualifier, registered match pulse and saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1010,
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    // The oldest history bit is only ever needed as part of the next compare,
    // so only MAX_LEN-1 bits are stored; hist_d carries the full window.
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               y_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] len_mask;
    logic               accept;
    logic               match;
    logic               cfg_ok;
    logic               cnt_sat;

    always_comb begin
        hist_d = {hist_q, din};
        fill_d = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        accept  = din_valid && !cfg_load;
        match   = accept && (fill_d >= len_q) &&
                  (((hist_d ^ pattern_q) & len_mask) == '0);
        cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        cnt_sat = &cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            y_q       <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            y_q <= match;

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (match && !cnt_sat) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (cfg_load) begin
                if (cfg_ok) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    hist_q    <= '0;
                    fill_q    <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (din_valid) begin
                hist_q <= hist_d[MAX_LEN-2:0];
                // Non-overlapping mode demands len fresh bits for the next hit.
                fill_q <= (match && !overlap_q) ? '0 : fill_d;
            end
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Parametrised, run-time programmable serial bit-pattern detector. It generalises the fixed 4-bit Mealy detector. It adds:
- a loadable pattern of 1..MAX_LEN bits
- selectable overlapping or non-overlapping detection
- an input-valid qualifier
- a registered match pulse
- a saturating match counter

It sits on a serial bit stream (framing/sync-word search) and is configured by a local controller.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of match counter
DEF_PATTERN, 8'b0000_1010, reset pattern (LSB-aligned, bit DEF_LEN-1 received first)
DEF_LEN, 4, reset pattern length
DEF_OVERLAP, 1, reset overlap mode (1 = overlapping)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  1  serial data bit
din_valid  input  1  din sampled only when 1
cfg_load  input  1  one-cycle strobe: load cfg_* fields
cfg_pattern  input  MAX_LEN  new pattern, LSB-aligned
cfg_len  input  $clog2(MAX_LEN+1)  new pattern length
cfg_overlap  input  1  new overlap mode
cnt_clr  input  1  clear match counter
y  output  1  match pulse, high one cycle
match_cnt  output  CNT_W  saturating match count
cfg_err  output  1  sticky: illegal cfg_len was presented

Behaviour:
- Reset (rst=1 at clk edge):
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP
  - hist=0, fill=0
  - y=0, match_cnt=0, cfg_err=0
  - rst overrides every other input, including mid-stream and mid-config.
- State:
  - hist: MAX_LEN-bit shift history, newest bit at hist[0].
  - fill: 0..MAX_LEN, number of valid bits held since the last clear.
- Accepted bit (din_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], din}
  - fill_n = min(fill+1, MAX_LEN)
  - match = (fill_n >= len) && (hist_n[len-1:0] == pattern[len-1:0]); bits above len are masked off both sides.
  - Registered update: hist<=hist_n; fill<=fill_n.
  - If match and overlap=0, fill<=0. The next match needs len fresh bits.
  - If match and overlap=1, fill is retained, so a suffix may start the next match.
- Output y:
  - y<=match, so y is high for exactly the cycle after the edge that accepted the completing bit (latency 1 clk).
  - y=0 in any cycle following an edge with din_valid=0.
- din_valid=0: hist, fill and counter hold; y<=0.
- Match counter:
  - On match, match_cnt increments and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets match_cnt<=0. If cnt_clr and match coincide, the clear wins and the result is 0.
- Configuration (cfg_load=1):
  - Legal when 1 <= cfg_len <= MAX_LEN. Then pattern/len/overlap <= cfg_*, hist<=0, fill<=0, y<=0.
  - cfg_load has priority over din_valid. A bit presented in the same cycle is discarded and not counted.
  - match_cnt is unaffected by cfg_load.
  - Illegal cfg_len (0 or > MAX_LEN): configuration is unchanged, hist/fill untouched, cfg_err<=1. cfg_err stays set until rst.
- len=1: every accepted bit equal to pattern[0] matches. In non-overlap mode fill returns to 0 each match, with no other effect.
- fill saturation at MAX_LEN is required so long streams never wrap the comparison qualifier.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset defaults (1010, overlap) with din_valid=1 stream 1,0,1,0,1,0 -> y pulses the cycle after bit 4 and after bit 6; match_cnt=2; cfg_err=0.
2. cfg_load pattern=1010, len=4, overlap=0, then stream 1,0,1,0,1,0,1,0 -> y after bit 4 and bit 8 only; match_cnt=2.
3. Stream 1,0,x(din_valid=0 for 3 cycles),1,0 with default config -> single y pulse the cycle after the final 0; no pulse during stalled cycles.
4. cfg_load pattern=8'b1110_0101, len=8, then 0,1,1,1,0,0,1,0,1 -> one y pulse after bit 9 (match on bits 2..9). Then cfg_load with cfg_len=0 -> cfg_err=1 and config retained; replaying the 8-bit pattern -> y pulses again.
5. CNT_W=2, pattern len=1 pattern=1, stream 1 x5 -> match_cnt sequence 1,2,3,3,3. cnt_clr asserted together with a matching bit -> match_cnt=0 next cycle.
6. Mid-pattern events:
   - Stream 1,0,1, then cfg_load (same pattern) coincident with din=0, din_valid=1 -> no y and bit discarded; a fresh 1,0,1,0 is required for the next y.
   - Stream 1,0,1, then rst -> no y and all outputs 0.
